// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready pipelined ALU with carry/zero/negative/overflow flags
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand beat handshake (a, b, select)
//   a, b                  operands; b[SHW-1:0] is the shift amount for shifts
//   select                opcode: ADD SUB AND OR XOR NOT SRL SLL (000..111)
//   out_valid / out_ready result beat handshake
//   result, carry, zero, negative, overflow   registered result and flags
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);
    logic             v1, v2, rdy1, rdy2;
    logic [WIDTH-1:0] a1, b1, r_n;
    logic [2:0]       s1;
    logic             c_n, o_n;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum, diff, srl_x, sll_x;

    assign rdy2      = !v2 || out_ready;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v2;
    assign sh        = b1[SHW-1:0];
    assign sum       = {1'b0, a1} + {1'b0, b1};
    assign diff      = {1'b0, a1} - {1'b0, b1};
    // one guard bit catches the last bit shifted out; a zero shift leaves it 0
    assign srl_x     = {a1, 1'b0} >> sh;
    assign sll_x     = {1'b0, a1} << sh;

    always_comb begin
        r_n = '0;
        c_n = 1'b0;
        o_n = 1'b0;
        case (s1)
            3'd0: begin
                r_n = sum[WIDTH-1:0];
                c_n = sum[WIDTH];
                o_n = (a1[WIDTH-1] == b1[WIDTH-1]) && (sum[WIDTH-1] != a1[WIDTH-1]);
            end
            3'd1: begin
                r_n = diff[WIDTH-1:0];
                c_n = diff[WIDTH];
                o_n = (a1[WIDTH-1] != b1[WIDTH-1]) && (diff[WIDTH-1] != a1[WIDTH-1]);
            end
            3'd2: r_n = a1 & b1;
            3'd3: r_n = a1 | b1;
            3'd4: r_n = a1 ^ b1;
            3'd5: r_n = ~a1;
            3'd6: begin
                r_n = srl_x[WIDTH:1];
                c_n = srl_x[0];
            end
            3'd7: begin
                r_n = sll_x[WIDTH-1:0];
                c_n = sll_x[WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            s1 <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1 <= a;
                b1 <= b;
                s1 <= select;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                result   <= r_n;
                carry    <= c_n;
                zero     <= (r_n == '0);
                negative <= r_n[WIDTH-1];
                overflow <= o_n;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=8)
module tb_alu_pipe;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [7:0] a = 0, b = 0, result;
    logic [2:0] select = 0;
    logic       carry, zero, negative, overflow;
    logic [15:0] obs;
    int n_pass = 0, n_tot = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .select(select), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign obs = {3'b0, out_valid, result, carry, zero, negative, overflow};

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a, b, r;
        logic c, z, n, v;
    } vec_t;

    vec_t tbl[14];
    logic [11:0] q[$];
    logic [11:0] exp_s[10];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic iv, input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb, input logic ordy);
        in_valid = iv;
        select = op;
        a = aa;
        b = bb;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: integer arithmetic on the opcode definitions, returns {result, c, z, n, v}
    function automatic logic [11:0] model(input logic [2:0] op, input int x, input int y);
        int r, c, v, sx, sy, n;
        r = 0; c = 0; v = 0;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        n = y % 8;
        case (op)
            3'd0: begin r = x + y; c = (r > 255); v = (sx + sy > 127 || sx + sy < -128); r = r % 256; end
            3'd1: begin r = (x - y + 256) % 256; c = (x < y); v = (sx - sy > 127 || sx - sy < -128); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = 255 - x;
            3'd6: begin r = x / (1 << n); c = (n > 0) ? (x / (1 << (n - 1))) % 2 : 0; end
            default: begin r = (x * (1 << n)) % 256; c = ((x * (1 << n)) / 256) % 2; end
        endcase
        return {r[7:0], c[0], r == 0, r >= 128, v[0]};
    endfunction

    initial begin
        tbl[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{3'd4, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{3'd7, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3'd6, 8'h81, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{3'd5, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd3, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{3'd7, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{3'd6, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset state
        tick();
        tick();
        chk("reset_out", obs, {4'b0000, 8'h00, 4'b0100});
        chk("reset_in_ready", {15'b0, in_ready}, 16'd1);
        #2 rst = 0;
        tick();

        // directed vectors, 2-cycle latency with out_ready high
        for (int i = 0; i < 14; i++) begin
            drive(1, tbl[i].op, tbl[i].a, tbl[i].b, 1);
            tick();
            drive(0, 0, 0, 0, 1);
            tick();
            chk($sformatf("vec%0d", i), obs, {4'b0001, tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].n, tbl[i].v});
        end
        tick();

        // backpressure: two beats held, third waits
        drive(1, 0, 1, 1, 0); #1 chk("bp_rdy0", {15'b0, in_ready}, 16'd1); tick();
        drive(1, 0, 2, 2, 0); #1 chk("bp_rdy1", {15'b0, in_ready}, 16'd1); tick();
        drive(1, 0, 3, 3, 0); #1 chk("bp_full", {15'b0, in_ready}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", obs, {4'b0001, 8'h02, 4'b0000});
            chk("bp_hold_rdy", {15'b0, in_ready}, 16'd0);
            tick();
        end
        drive(1, 0, 3, 3, 1); #1 chk("bp_release_rdy", {15'b0, in_ready}, 16'd1);
        chk("bp_out0", obs, {4'b0001, 8'h02, 4'b0000});
        tick();
        drive(0, 0, 0, 0, 1);
        chk("bp_out1", obs, {4'b0001, 8'h04, 4'b0000});
        tick();
        chk("bp_out2", obs, {4'b0001, 8'h06, 4'b0000});
        tick();
        chk("bp_empty", {15'b0, out_valid}, 16'd0);

        // streaming: 10 back-to-back beats, exact 2-cycle latency
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 10) begin
                drive(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1);
                exp_s[cyc] = model(select, int'(a), int'(b));
            end else drive(0, 0, 0, 0, 1);
            tick();
            if (cyc >= 1 && cyc <= 10) chk($sformatf("stream%0d", cyc - 1), obs, {4'b0001, exp_s[cyc - 1]});
            else chk("stream_idle", {15'b0, out_valid}, 16'd0);
        end

        // random valid/ready traffic against a scoreboard
        begin
            logic stalled;
            logic [15:0] held;
            stalled = 0;
            held = 0;
            for (int cyc = 0; cyc < 410; cyc++) begin
                if (cyc < 400) drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
                else drive(0, 0, 0, 0, 1);
                #2;
                if (stalled) chk("rand_hold", obs, held);
                if (in_valid && in_ready) q.push_back(model(select, int'(a), int'(b)));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("rand_spurious", {15'b0, out_valid}, 16'd0);
                    else chk("rand_beat", obs, {4'b0001, q.pop_front()});
                end
                stalled = out_valid && !out_ready;
                held = obs;
                tick();
            end
            chk("rand_drain", 16'(q.size()), 16'd0);
        end

        // asynchronous reset while both stages are full and stalled
        drive(1, 0, 9, 9, 0); tick();
        drive(1, 0, 5, 5, 0); tick();
        drive(0, 0, 0, 0, 0);
        #1 chk("rst_pre_full", {15'b0, in_ready}, 16'd0);
        #1 rst = 1;
        #1 chk("rst_async_out", obs, {4'b0000, 8'h00, 4'b0100});
        chk("rst_async_rdy", {15'b0, in_ready}, 16'd1);
        tick();
        chk("rst_held", obs, {4'b0000, 8'h00, 4'b0100});
        #2 rst = 0;
        drive(1, 0, 8'h10, 8'h22, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("rst_no_stale", obs, {4'b0000, 8'h00, 4'b0100});
        tick();
        chk("rst_next_beat", obs, {4'b0001, 8'h32, 4'b0000});
        tick();
        chk("rst_after", {15'b0, out_valid}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor of the team's 4-bit combinational ALU.
- Width is set by `WIDTH`. Operands and opcode are registered.
- Produces result plus carry/zero/negative/overflow flags through a 2-stage valid/ready pipeline with full backpressure.
- Sits between an operand-issue stage and a writeback/consumer stage in the datapath.

Parameters:
- `WIDTH`, default 8: operand/result width in bits. Must be a power of two, ≥4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width, derived. Not to be overridden.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept an operand beat this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B. For shifts, `b[SHW-1:0]` is the shift amount.
- `select`  in  3  opcode (encoding below).
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts result beat.
- `result`  out  WIDTH  operation result.
- `carry`  out  1  carry/borrow/shifted-out bit.
- `zero`  out  1  `result == 0`.
- `negative`  out  1  `result[WIDTH-1]`.
- `overflow`  out  1  signed overflow (add/sub only).

Behaviour:
- Opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 SRL a by `b[SHW-1:0]` (logical, zero fill); 111 SLL a by `b[SHW-1:0]`.
- Arithmetic: modulo 2^WIDTH, unsigned wrap.
- Carry, ADD: carry-out of the WIDTH+1-bit sum.
- Carry, SUB: borrow, i.e. 1 iff a < b unsigned.
- Carry, SRL by n>0: `a[n-1]`. SLL by n>0: `a[WIDTH-n]`. Shift by n=0: carry=0 and result=a.
- Carry is 0 for AND/OR/XOR/NOT.
- Overflow, ADD: a and b share a sign and result sign differs.
- Overflow, SUB: a and b signs differ and result sign differs from a.
- Overflow is 0 for all other opcodes.
- Pipeline: stage 1 registers a, b, select when `in_valid && in_ready`. Stage 2 registers the computed result and flags.
- Latency: a beat accepted at edge N is presented at `out_valid` after edge N+1, i.e. 2 cycles when unstalled.
- Stage 2 is ready when `!v2 || out_ready`. Stage 1 is ready when `!v1 || stage2_ready`. `in_ready` equals stage 1 ready (combinational from `out_ready`; no skid buffer).
- Throughput: 1 beat/cycle while `out_ready` is high.
- Backpressure: while `out_valid && !out_ready`, `result` and all flags hold stable and stage 2 does not update.
- Stall capacity: with `out_ready` low, at most 2 beats are held; `in_ready` falls once both stages are full.
- Simultaneous out-handshake and in-handshake in the same cycle: both complete, no bubble, no loss, no duplication.
- Output beats keep input order.
- A beat with `in_valid` low is never captured. Data on a, b, select is don't-care when `in_valid` is low.
- Reset (asynchronous, any time, including mid-stall):
  - `v1`, `v2` clear immediately; in-flight beats are discarded.
  - `out_valid`=0, `result`=0, `carry`=0, `overflow`=0, `negative`=0, `zero`=1.
  - `in_ready` reads 1 while in reset and after release.
- Flags are registered together with `result` and always describe the presented result.

Test Plan:
- WIDTH=8, `out_ready`=1, ADD a=0xF0 b=0x20 → 2 cycles later `result`=0x10, carry=1, overflow=0, zero=0, negative=0.
- ADD 0x7F+0x01 → 0x80, overflow=1, negative=1, carry=0. SUB 0x05-0x07 → 0xFE, carry=1, negative=1, overflow=0. SUB 0x80-0x01 → 0x7F, overflow=1. XOR 0x5A^0x5A → 0x00, zero=1.
- SLL a=0x81 b=1 → 0x02, carry=1. SRL a=0x81 b=3 → 0x10, carry=0. SRL a=0x81 b=0 → 0x81, carry=0. NOT 0x0F → 0xF0, negative=1.
- Backpressure: `out_ready`=0, drive 3 consecutive beats (ADD 1+1, 2+2, 3+3) → `in_ready` low after 2 accepted, `out_valid` high with `result`=0x02 held stable. Raise `out_ready` → outputs 0x02, 0x04, then the third beat accepted and output 0x06, in order, none lost.
- Streaming: `out_ready`=1, 10 back-to-back random beats → 10 outputs matching a reference model, 1 per cycle, 2-cycle latency, no bubbles.
- Assert `rst` asynchronously mid-clock while both stages are full and stalled → `out_valid` drops immediately, `result`=0, `zero`=1, `in_ready`=1. Next accepted beat emerges with normal 2-cycle latency; no stale beat appears.
